// File: rtl/perip_sram_ctrl_if.sv
// -----------------------------------------------------------------------------
// perip_sram_ctrl_if
// Request/response port of the asynchronous-SRAM controller.
//   master modport : on-chip requester (bus bridge, DMA)
//   slave  modport : perip_sram_ctrl
// Signals:
//   req_valid  request present
//   req_ready  controller idle; request accepted when valid && ready
//   req_wr     1 = write, 0 = read
//   req_addr   word address (ADDRW bits)
//   req_wdata  write data (DATAW bits)
//   req_be     byte enables, 1 = lane active (DATAW/8 bits)
//   rsp_valid  one-cycle pulse, access complete
//   rsp_rdata  read data, valid with rsp_valid after a read
// -----------------------------------------------------------------------------
interface perip_sram_ctrl_if #(
   parameter int ADDRW = 20,
   parameter int DATAW = 16
) ();
   localparam int NB = DATAW / 8;

   logic             req_valid;
   logic             req_ready;
   logic             req_wr;
   logic [ADDRW-1:0] req_addr;
   logic [DATAW-1:0] req_wdata;
   logic [NB-1:0]    req_be;
   logic             rsp_valid;
   logic [DATAW-1:0] rsp_rdata;

   modport master (
      output req_valid, req_wr, req_addr, req_wdata, req_be,
      input  req_ready, rsp_valid, rsp_rdata
   );

   modport slave (
      input  req_valid, req_wr, req_addr, req_wdata, req_be,
      output req_ready, rsp_valid, rsp_rdata
   );
endinterface

// File: rtl/perip_sram_ctrl.sv
// -----------------------------------------------------------------------------
// perip_sram_ctrl
// Asynchronous-SRAM controller with valid/ready request port, programmable
// read/write wait states, byte-lane enables and a data-bus drive enable.
// Every pin output comes straight from a register.
// Ports:
//   CLK, RSTn            clock (rising edge), async active-low reset
//   bus (slave)          request/response port, see perip_sram_ctrl_if
//   SRAM_CS_Pin          chip select, active-low
//   SRAM_OE_Pin          output enable, active-low
//   SRAM_WR_Pin          write enable, active-low
//   SRAM_BE_Pin          byte-lane select, active-low
//   SRAM_ADDR_Pin        word address
//   SRAM_DATA_IN_Pin     data driven towards the SRAM
//   SRAM_DATA_T_Pin      1 = bus tristated, 0 = controller drives
//   SRAM_DATA_OUT_Pin    data returned by the SRAM
// -----------------------------------------------------------------------------
module perip_sram_ctrl #(
   parameter int ADDRW   = 20,
   parameter int DATAW   = 16,
   parameter int WAIT_RD = 2,
   parameter int WAIT_WR = 1
) (
   input  logic             CLK,
   input  logic             RSTn,
   perip_sram_ctrl_if.slave bus,
   output logic             SRAM_CS_Pin,
   output logic             SRAM_OE_Pin,
   output logic             SRAM_WR_Pin,
   output logic [DATAW/8-1:0] SRAM_BE_Pin,
   output logic [ADDRW-1:0] SRAM_ADDR_Pin,
   output logic [DATAW-1:0] SRAM_DATA_IN_Pin,
   output logic             SRAM_DATA_T_Pin,
   input  logic [DATAW-1:0] SRAM_DATA_OUT_Pin
);
   localparam int NB    = DATAW / 8;
   localparam int WMAX  = (WAIT_RD > WAIT_WR) ? WAIT_RD : WAIT_WR;
   localparam int CNTW  = (WMAX < 2) ? 1 : $clog2(WMAX + 1);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RD       = 3'd1,
      ST_WR_SETUP = 3'd2,
      ST_WR_PULSE = 3'd3,
      ST_WR_HOLD  = 3'd4
   } state_t;

   state_t            state_r;
   logic [CNTW-1:0]   cnt_r;
   logic              ready_r;
   logic              rsp_valid_r;
   logic [DATAW-1:0]  rdata_r;
   logic              cs_n_r;
   logic              oe_n_r;
   logic              wr_n_r;
   logic [NB-1:0]     be_n_r;
   logic [ADDRW-1:0]  addr_r;
   logic [DATAW-1:0]  wdata_r;
   logic              t_r;

   // Zero every byte lane whose enable is clear.
   function automatic logic [DATAW-1:0] mask_lanes(input logic [DATAW-1:0] data,
                                                    input logic [NB-1:0]    be);
      logic [DATAW-1:0] m;
      m = '0;
      for (int i = 0; i < NB; i++) begin
         m[i*8 +: 8] = be[i] ? data[i*8 +: 8] : 8'h00;
      end
      return m;
   endfunction

   // Access sequencer: state, wait counter and all pin/response registers.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_r     <= ST_IDLE;
         cnt_r       <= '0;
         ready_r     <= 1'b1;
         rsp_valid_r <= 1'b0;
         rdata_r     <= '0;
         cs_n_r      <= 1'b1;
         oe_n_r      <= 1'b1;
         wr_n_r      <= 1'b1;
         be_n_r      <= {NB{1'b1}};
         addr_r      <= '0;
         wdata_r     <= '0;
         t_r         <= 1'b1;
      end else begin
         rsp_valid_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (bus.req_valid) begin
                  addr_r  <= bus.req_addr;
                  wdata_r <= bus.req_wdata;
                  be_n_r  <= ~bus.req_be;
                  cs_n_r  <= 1'b0;
                  ready_r <= 1'b0;
                  if (bus.req_wr) begin
                     cnt_r   <= CNTW'(WAIT_WR);
                     t_r     <= 1'b0;
                     state_r <= ST_WR_SETUP;
                  end else begin
                     cnt_r   <= CNTW'(WAIT_RD);
                     oe_n_r  <= 1'b0;
                     state_r <= ST_RD;
                  end
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_RD: begin
               if (cnt_r == '0) begin
                  // be_n_r still holds the lanes of this access (active-low).
                  rdata_r     <= mask_lanes(SRAM_DATA_OUT_Pin, ~be_n_r);
                  cs_n_r      <= 1'b1;
                  oe_n_r      <= 1'b1;
                  be_n_r      <= {NB{1'b1}};
                  ready_r     <= 1'b1;
                  rsp_valid_r <= 1'b1;
                  state_r     <= ST_IDLE;
               end else begin
                  cnt_r <= cnt_r - CNTW'(1);
               end
            end
            ST_WR_SETUP: begin
               wr_n_r  <= 1'b0;
               state_r <= ST_WR_PULSE;
            end
            ST_WR_PULSE: begin
               if (cnt_r == '0) begin
                  wr_n_r  <= 1'b1;
                  state_r <= ST_WR_HOLD;
               end else begin
                  cnt_r <= cnt_r - CNTW'(1);
               end
            end
            ST_WR_HOLD: begin
               // Release the bus in the same cycle the chip is deselected.
               cs_n_r      <= 1'b1;
               t_r         <= 1'b1;
               be_n_r      <= {NB{1'b1}};
               ready_r     <= 1'b1;
               rsp_valid_r <= 1'b1;
               state_r     <= ST_IDLE;
            end
            default: begin
               cs_n_r  <= 1'b1;
               oe_n_r  <= 1'b1;
               wr_n_r  <= 1'b1;
               be_n_r  <= {NB{1'b1}};
               t_r     <= 1'b1;
               ready_r <= 1'b1;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.req_ready     = ready_r;
   assign bus.rsp_valid     = rsp_valid_r;
   assign bus.rsp_rdata     = rdata_r;
   assign SRAM_CS_Pin       = cs_n_r;
   assign SRAM_OE_Pin       = oe_n_r;
   assign SRAM_WR_Pin       = wr_n_r;
   assign SRAM_BE_Pin       = be_n_r;
   assign SRAM_ADDR_Pin     = addr_r;
   assign SRAM_DATA_IN_Pin  = wdata_r;
   assign SRAM_DATA_T_Pin   = t_r;
endmodule

// File: tb/tb_perip_sram_ctrl.sv
// -----------------------------------------------------------------------------
// tb_perip_sram_ctrl
// Directed bench for perip_sram_ctrl (WAIT_RD=2, WAIT_WR=1) with a small
// asynchronous SRAM model (256 words, indexed by the low address byte).
// -----------------------------------------------------------------------------
module tb_perip_sram_ctrl;
   localparam int ADDRW = 20;
   localparam int DATAW = 16;
   localparam int NB    = 2;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             sram_cs;
   logic             sram_oe;
   logic             sram_wr;
   logic [NB-1:0]    sram_be;
   logic [ADDRW-1:0] sram_addr;
   logic [DATAW-1:0] sram_din;
   logic             sram_t;
   logic [DATAW-1:0] sram_dout;
   logic [DATAW-1:0] mem [0:255];

   int n_checks = 0;
   int n_fail   = 0;

   // per-cycle traces of one access, bit k-1 = cycle k after the accept edge
   logic [15:0] cs_lo_v, oe_lo_v, wr_lo_v, t_lo_v, rsp_v, rdy_v, addr_ok_v;
   logic [NB-1:0]    be_c2;
   logic [DATAW-1:0] din_c2;
   logic [DATAW-1:0] rd_cap;
   logic             any_rsp;

   perip_sram_ctrl_if #(.ADDRW(ADDRW), .DATAW(DATAW)) bus ();

   perip_sram_ctrl #(
      .ADDRW(ADDRW), .DATAW(DATAW), .WAIT_RD(2), .WAIT_WR(1)
   ) dut (
      .CLK               (clk),
      .RSTn              (rst_n),
      .bus               (bus),
      .SRAM_CS_Pin       (sram_cs),
      .SRAM_OE_Pin       (sram_oe),
      .SRAM_WR_Pin       (sram_wr),
      .SRAM_BE_Pin       (sram_be),
      .SRAM_ADDR_Pin     (sram_addr),
      .SRAM_DATA_IN_Pin  (sram_din),
      .SRAM_DATA_T_Pin   (sram_t),
      .SRAM_DATA_OUT_Pin (sram_dout)
   );

   always #5 clk = ~clk;

   // SRAM model: read while CS and OE are low, write on the rising edge of WE.
   assign sram_dout = (!sram_cs && !sram_oe) ? mem[sram_addr[7:0]] : 16'hDEAD;

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
      mem[8'h10] = 16'hBEEF;
      mem[8'h30] = 16'hC3C3;
      forever begin
         @(posedge sram_wr);
         if (sram_cs === 1'b0) begin
            if (sram_be[0] === 1'b0) mem[sram_addr[7:0]][7:0]  = sram_din[7:0];
            if (sram_be[1] === 1'b0) mem[sram_addr[7:0]][15:8] = sram_din[15:8];
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Present one request in the current cycle and trace n following cycles.
   task automatic run(input logic wr, input logic [ADDRW-1:0] a, input logic [DATAW-1:0] d,
                      input logic [NB-1:0] be, input int n);
      cs_lo_v = '0; oe_lo_v = '0; wr_lo_v = '0; t_lo_v = '0;
      rsp_v = '0; rdy_v = '0; addr_ok_v = '0;
      be_c2 = '0; din_c2 = '0; rd_cap = 16'hFFFF;
      bus.req_valid = 1'b1;
      bus.req_wr    = wr;
      bus.req_addr  = a;
      bus.req_wdata = d;
      bus.req_be    = be;
      for (int k = 1; k <= n; k++) begin
         @(negedge clk);
         if (k == 1) bus.req_valid = 1'b0;
         cs_lo_v[k-1]   = ~sram_cs;
         oe_lo_v[k-1]   = ~sram_oe;
         wr_lo_v[k-1]   = ~sram_wr;
         t_lo_v[k-1]    = ~sram_t;
         rsp_v[k-1]     = bus.rsp_valid;
         rdy_v[k-1]     = bus.req_ready;
         addr_ok_v[k-1] = (sram_addr == a);
         if (k == 2) begin
            be_c2  = sram_be;
            din_c2 = sram_din;
         end
         if (bus.rsp_valid) rd_cap = bus.rsp_rdata;
      end
   endtask

   initial begin
      rst_n         = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_wr    = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      bus.req_be    = '0;

      // reset state
      repeat (2) @(negedge clk);
      check("rst_ctl", {24'd0, bus.req_ready, bus.rsp_valid, sram_cs, sram_oe, sram_wr, sram_t, sram_be},
            32'h000000BF);
      check("rst_addr",  {12'd0, sram_addr}, 32'd0);
      check("rst_din",   {16'd0, sram_din},  32'd0);
      check("rst_rdata", {16'd0, bus.rsp_rdata}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // read 0x10, be=11
      run(1'b0, 20'h00010, 16'h0000, 2'b11, 5);
      check("rd_oe_low",  {16'd0, oe_lo_v}, 32'h07);
      check("rd_cs_low",  {16'd0, cs_lo_v}, 32'h07);
      check("rd_rsp",     {16'd0, rsp_v},   32'h08);
      check("rd_ready",   {16'd0, rdy_v},   32'h18);
      check("rd_t_high",  {16'd0, t_lo_v},  32'h00);
      check("rd_data",    {16'd0, rd_cap},  32'hBEEF);

      // write 0x1234 to 0x20, be=11
      run(1'b1, 20'h00020, 16'h1234, 2'b11, 6);
      check("wr_we_low",  {16'd0, wr_lo_v},   32'h06);
      check("wr_t_low",   {16'd0, t_lo_v},    32'h0F);
      check("wr_cs_low",  {16'd0, cs_lo_v},   32'h0F);
      check("wr_oe_high", {16'd0, oe_lo_v},   32'h00);
      check("wr_addr",    {16'd0, addr_ok_v}, 32'h3F);
      check("wr_rsp",     {16'd0, rsp_v},     32'h10);
      check("wr_din",     {16'd0, din_c2},    32'h1234);
      check("wr_mem",     {16'd0, mem[8'h20]}, 32'h1234);
      check("wr_rdata_kept", {16'd0, bus.rsp_rdata}, 32'hBEEF);

      // partial write be=01 then full read of the same word
      run(1'b1, 20'h00030, 16'hAA55, 2'b01, 6);
      check("pw_be_pins", {30'd0, be_c2}, 32'h2);
      check("pw_mem",     {16'd0, mem[8'h30]}, 32'hC355);
      run(1'b0, 20'h00030, 16'h0000, 2'b11, 5);
      check("pw_rd_data", {16'd0, rd_cap}, 32'hC355);

      // back-to-back read, write, read with req_valid held
      cs_lo_v = '0; rsp_v = '0; rd_cap = 16'hFFFF;
      bus.req_valid = 1'b1;
      bus.req_wr    = 1'b0;
      bus.req_addr  = 20'h00010;
      bus.req_be    = 2'b11;
      for (int k = 1; k <= 14; k++) begin
         @(negedge clk);
         cs_lo_v[k-1] = sram_cs;
         rsp_v[k-1]   = bus.rsp_valid;
         if (k == 4) check("b2b_rd1", {16'd0, bus.rsp_rdata}, 32'hBEEF);
         if (k == 1) begin
            bus.req_wr    = 1'b1;
            bus.req_addr  = 20'h00040;
            bus.req_wdata = 16'h5A5A;
         end
         if (k == 5) begin
            bus.req_wr   = 1'b0;
            bus.req_addr = 20'h00040;
         end
         if (k == 13) begin
            bus.req_valid = 1'b0;
            rd_cap = bus.rsp_rdata;
         end
      end
      check("b2b_cs_high", {16'd0, cs_lo_v}, 32'h3108);
      check("b2b_rsp",     {16'd0, rsp_v},   32'h1108);
      check("b2b_rd2",     {16'd0, rd_cap},  32'h5A5A);

      // reset during the second WR_PULSE cycle
      bus.req_valid = 1'b1;
      bus.req_wr    = 1'b1;
      bus.req_addr  = 20'h00050;
      bus.req_wdata = 16'h7777;
      bus.req_be    = 2'b11;
      repeat (3) @(negedge clk);
      bus.req_valid = 1'b0;
      check("rst_mid_we_low", {31'd0, sram_wr}, 32'd0);
      rst_n = 1'b0;
      #1;
      check("rst_mid_pins", {29'd0, sram_wr, sram_cs, sram_t}, 32'h7);
      check("rst_mid_ready", {31'd0, bus.req_ready}, 32'd1);
      any_rsp = bus.rsp_valid;
      repeat (2) begin
         @(negedge clk);
         any_rsp = any_rsp | bus.rsp_valid;
      end
      rst_n = 1'b1;
      @(negedge clk);
      any_rsp = any_rsp | bus.rsp_valid;
      check("rst_mid_no_rsp", {31'd0, any_rsp}, 32'd0);
      run(1'b0, 20'h00010, 16'h0000, 2'b11, 5);
      check("post_rst_rsp",  {16'd0, rsp_v},  32'h08);
      check("post_rst_data", {16'd0, rd_cap}, 32'hBEEF);

      // read with be=00
      run(1'b0, 20'h00010, 16'h0000, 2'b00, 5);
      check("be0_pins", {30'd0, be_c2}, 32'h3);
      check("be0_rsp",  {16'd0, rsp_v},  32'h08);
      check("be0_data", {16'd0, rd_cap}, 32'h0000);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
